adc_view_sequencer: RTL and testbench

Registered, parametrised display-view selector for NUM_CH ADC channels.
- Per channel, it selects the RAW, AVG, VOLT (mV) or PEAK (max mV since clear) view and drives a single value, decimal-point pattern and channel index to the 7-segment driver.
- Channel is either manually selected or auto-scanned with a programmable dwell time.
- Sits between the per-ADC processing chains (raw/averaging/mV conversion) and the display formatter.

---
 rtl/adc_view_sequencer_if.sv | 47 ++++
 rtl/adc_view_sequencer.sv | 122 ++++++++++++
 tb/tb_adc_view_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_view_sequencer_if.sv
// rtl/adc_view_sequencer_if.sv - control, view-data and display bundle for adc_view_sequencer
//
// Purpose: groups everything between the per-ADC processing chains, the
// front-panel controls and the 7-segment formatter into one bundle.
//   master : the upstream side (controls + per-channel views), sinks display
//   slave  : the sequencer, sinks controls/views, drives the display fields
// Signals:
//   display_mode  2       00=RAW 01=AVG 10=VOLT 11=PEAK
//   auto_scan     1       rotate channels on the dwell timer
//   ch_sel        CW      manual channel select (clamped to NUM_CH-1)
//   hold          1       freeze display and dwell timer
//   peak_clr      1       clear all peak registers
//   sample_valid  NUM_CH  per-channel new-mV strobe
//   raw_flat/avg_flat/mv_flat  NUM_CH*DATA_W, channel i at [i*DATA_W +: DATA_W]
//   disp_val/decimal_point/disp_ch/disp_changed  registered display outputs
interface adc_view_sequencer_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16
);
  localparam int CW = $clog2(NUM_CH);

  logic [1:0]             display_mode;
  logic                   auto_scan;
  logic [CW-1:0]          ch_sel;
  logic                   hold;
  logic                   peak_clr;
  logic [NUM_CH-1:0]      sample_valid;
  logic [NUM_CH*DATA_W-1:0] raw_flat;
  logic [NUM_CH*DATA_W-1:0] avg_flat;
  logic [NUM_CH*DATA_W-1:0] mv_flat;
  logic [DATA_W-1:0]      disp_val;
  logic [3:0]             decimal_point;
  logic [CW-1:0]          disp_ch;
  logic                   disp_changed;

  modport master (
    output display_mode, auto_scan, ch_sel, hold, peak_clr,
    output sample_valid, raw_flat, avg_flat, mv_flat,
    input  disp_val, decimal_point, disp_ch, disp_changed
  );

  modport slave (
    input  display_mode, auto_scan, ch_sel, hold, peak_clr,
    input  sample_valid, raw_flat, avg_flat, mv_flat,
    output disp_val, decimal_point, disp_ch, disp_changed
  );
endinterface

// File: rtl/adc_view_sequencer.sv
// rtl/adc_view_sequencer.sv - per-channel RAW/AVG/VOLT/PEAK display view selector with auto-scan
//
// Purpose: picks one channel (manual or auto-scanned with a dwell timer) and
// one view of it, and registers value, decimal-point pattern and channel index
// for the 7-segment formatter. Tracks a per-channel peak of the mV view.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      adc_view_sequencer_if.slave (controls, channel views, display outputs)
module adc_view_sequencer #(
  parameter int          NUM_CH       = 3,
  parameter int          DATA_W       = 16,
  parameter int          DWELL_CYCLES = 100000000,
  parameter logic [3:0]  DP_VOLT      = 4'b1000
) (
  input logic clk,
  input logic reset_n,
  adc_view_sequencer_if.slave bus
);
  localparam int CW  = $clog2(NUM_CH);
  localparam int DCW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]  LAST_CH    = CW'(NUM_CH - 1);
  localparam logic [DCW-1:0] DWELL_LAST = DCW'(DWELL_CYCLES - 1);

  logic [DATA_W-1:0] raw_a  [NUM_CH];
  logic [DATA_W-1:0] avg_a  [NUM_CH];
  logic [DATA_W-1:0] mv_a   [NUM_CH];
  logic [DATA_W-1:0] peak   [NUM_CH];

  logic [CW-1:0]     scan_ptr;
  logic [DCW-1:0]    dwell_cnt;
  // Previous auto_scan level as seen by the scanner. Reset to 1 so that a
  // reset released with auto_scan already high restarts the scan at channel 0
  // instead of treating it as a fresh rising edge from ch_sel.
  logic              auto_q;

  logic [CW-1:0]     ch_clamped;
  logic              scanning;
  logic [CW-1:0]     cur_ch;
  logic [DCW-1:0]    dwell_eff;
  logic [DATA_W-1:0] new_val;
  logic [3:0]        new_dp;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      raw_a[i] = bus.raw_flat[i*DATA_W +: DATA_W];
      avg_a[i] = bus.avg_flat[i*DATA_W +: DATA_W];
      mv_a[i]  = bus.mv_flat[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    ch_clamped = (bus.ch_sel > LAST_CH) ? LAST_CH : bus.ch_sel;
    // Scanning only once auto_scan was already high last cycle; on its rising
    // edge the manual channel seeds the scan with a fresh dwell, and on its
    // falling edge the manual channel applies immediately.
    scanning   = bus.auto_scan && auto_q;
    cur_ch     = scanning ? scan_ptr : ch_clamped;
    dwell_eff  = scanning ? dwell_cnt : '0;

    new_val = '0;
    new_dp  = 4'b0000;
    case (bus.display_mode)
      2'b00: new_val = raw_a[cur_ch];
      2'b01: new_val = avg_a[cur_ch];
      2'b10: begin
        new_val = mv_a[cur_ch];
        new_dp  = DP_VOLT;
      end
      default: begin
        new_val = peak[cur_ch];
        new_dp  = DP_VOLT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_ptr          <= '0;
      dwell_cnt         <= '0;
      auto_q            <= 1'b1;
      bus.disp_val      <= '0;
      bus.decimal_point <= 4'b0000;
      bus.disp_ch       <= '0;
      bus.disp_changed  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) peak[i] <= '0;
    end else begin
      if (!bus.hold) begin
        auto_q <= bus.auto_scan;
        if (bus.auto_scan) begin
          if (dwell_eff == DWELL_LAST) begin
            dwell_cnt <= '0;
            scan_ptr  <= (cur_ch == LAST_CH) ? '0 : cur_ch + CW'(1);
          end else begin
            dwell_cnt <= dwell_eff + DCW'(1);
            scan_ptr  <= cur_ch;
          end
        end else begin
          dwell_cnt <= '0;
          scan_ptr  <= cur_ch;
        end
        bus.disp_val      <= new_val;
        bus.decimal_point <= new_dp;
        bus.disp_ch       <= cur_ch;
        bus.disp_changed  <= ({new_val, new_dp, cur_ch} !=
                              {bus.disp_val, bus.decimal_point, bus.disp_ch});
      end else begin
        bus.disp_changed <= 1'b0;
      end

      // Peaks keep tracking through hold; a sample arriving with peak_clr
      // replaces the cleared value.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.sample_valid[i]) begin
          if (bus.peak_clr || (mv_a[i] > peak[i])) peak[i] <= mv_a[i];
        end else if (bus.peak_clr) begin
          peak[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_view_sequencer.sv
// tb/tb_adc_view_sequencer.sv - self-checking bench for adc_view_sequencer
module tb_adc_view_sequencer;
  localparam int N     = 3;
  localparam int DW    = 16;
  localparam int DWELL = 4;
  localparam logic [3:0] DPV = 4'b1000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  adc_view_sequencer_if #(.NUM_CH(N), .DATA_W(DW)) bus();

  adc_view_sequencer #(
    .NUM_CH(N), .DATA_W(DW), .DWELL_CYCLES(DWELL), .DP_VOLT(DPV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [DW-1:0] m_peak [N];
  logic [DW-1:0] m_val;
  logic [3:0]    m_dp;
  int            m_ch;
  bit            m_chg;
  bit            m_auto_prev;
  int            m_start;
  int            m_elapsed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] flat, input int ch);
    return flat[ch*DW +: DW];
  endfunction

  task automatic set_ch(input int ch, input logic [DW-1:0] raw, input logic [DW-1:0] avg,
                        input logic [DW-1:0] mv);
    bus.raw_flat[ch*DW +: DW] = raw;
    bus.avg_flat[ch*DW +: DW] = avg;
    bus.mv_flat[ch*DW +: DW]  = mv;
  endtask

  // Predict the effect of the coming edge from the current inputs, take the
  // edge, then compare every output against the prediction.
  task automatic step(input string tag);
    int ch;
    int clamp;
    logic [DW-1:0] nv;
    logic [3:0] ndp;
    if (!reset_n) begin
      m_val = '0; m_dp = '0; m_ch = 0; m_chg = 1'b0;
      for (int i = 0; i < N; i++) m_peak[i] = '0;
      m_auto_prev = 1'b1; m_start = 0; m_elapsed = 0;
    end else begin
      clamp = (int'(bus.ch_sel) > N-1) ? N-1 : int'(bus.ch_sel);
      if (!bus.hold) begin
        if (bus.auto_scan && !m_auto_prev) begin
          m_start = clamp;
          m_elapsed = 0;
        end
        ch = bus.auto_scan ? (m_start + m_elapsed / DWELL) % N : clamp;
        case (bus.display_mode)
          2'd0: begin nv = slice(bus.raw_flat, ch); ndp = 4'b0000; end
          2'd1: begin nv = slice(bus.avg_flat, ch); ndp = 4'b0000; end
          2'd2: begin nv = slice(bus.mv_flat, ch);  ndp = DPV; end
          default: begin nv = m_peak[ch]; ndp = DPV; end
        endcase
        m_chg = (nv !== m_val) || (ndp !== m_dp) || (ch != m_ch);
        m_val = nv; m_dp = ndp; m_ch = ch;
        if (bus.auto_scan) m_elapsed++;
        m_auto_prev = bus.auto_scan;
      end else begin
        m_chg = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (bus.sample_valid[i]) begin
          if (bus.peak_clr || slice(bus.mv_flat, i) > m_peak[i]) m_peak[i] = slice(bus.mv_flat, i);
        end else if (bus.peak_clr) begin
          m_peak[i] = '0;
        end
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_val"}, 32'(bus.disp_val), 32'(m_val));
    check({tag, "_dp"},  32'(bus.decimal_point), 32'(m_dp));
    check({tag, "_ch"},  32'(bus.disp_ch), 32'(m_ch));
    check({tag, "_chg"}, 32'(bus.disp_changed), 32'(m_chg));
  endtask

  int exp_seq [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};
  int found;

  initial begin
    reset_n = 1'b0;
    bus.display_mode = 2'd0; bus.auto_scan = 1'b0; bus.ch_sel = '0;
    bus.hold = 1'b0; bus.peak_clr = 1'b0; bus.sample_valid = '0;
    bus.raw_flat = '0; bus.avg_flat = '0; bus.mv_flat = '0;
    step("reset0");
    step("reset1");
    check("reset_val_const", 32'(bus.disp_val), 32'd0);

    // Manual VOLT view of channel 1
    reset_n = 1'b1;
    bus.display_mode = 2'd2; bus.ch_sel = 2'd1;
    set_ch(1, 16'h1111, 16'h2222, 16'd1650);
    step("manual");
    check("manual_val_const", 32'(bus.disp_val), 32'd1650);
    check("manual_dp_const", 32'(bus.decimal_point), 32'b1000);
    check("manual_chg_const", 32'(bus.disp_changed), 32'd1);
    step("manual_steady");
    check("manual_pulse_const", 32'(bus.disp_changed), 32'd0);

    // Out-of-range ch_sel clamps to the last channel, RAW view
    bus.ch_sel = 2'd3; bus.display_mode = 2'd0;
    set_ch(2, 16'h0A5F, 16'h0123, 16'd3000);
    step("clamp");
    check("clamp_ch_const", 32'(bus.disp_ch), 32'd2);
    check("clamp_val_const", 32'(bus.raw_flat[2*DW +: DW]), 32'h0A5F);
    check("clamp_dp_const", 32'(bus.decimal_point), 32'd0);

    // Auto-scan from channel 0, then hold mid-dwell, then resume
    set_ch(0, 16'h00AA, 16'h00BB, 16'd100);
    bus.ch_sel = 2'd0; bus.auto_scan = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step("scan");
      check("scan_seq_const", 32'(bus.disp_ch), 32'(exp_seq[k]));
    end
    bus.hold = 1'b1;
    set_ch(0, 16'h5555, 16'h6666, 16'd7777);
    for (int k = 0; k < 10; k++) step("hold");
    bus.hold = 1'b0;
    for (int k = 0; k < 6; k++) step("resume");

    // Peak tracking on channel 0
    bus.auto_scan = 1'b0; bus.ch_sel = 2'd0; bus.display_mode = 2'd3;
    bus.peak_clr = 1'b1;
    step("peak_pre_clr");
    bus.peak_clr = 1'b0;
    bus.sample_valid = 3'b001;
    set_ch(0, 16'h0, 16'h0, 16'd500);  step("peak500");
    set_ch(0, 16'h0, 16'h0, 16'd1200); step("peak1200");
    check("peak_after500_const", 32'(bus.disp_val), 32'd500);
    set_ch(0, 16'h0, 16'h0, 16'd800);  step("peak800");
    check("peak_after1200_const", 32'(bus.disp_val), 32'd1200);
    bus.sample_valid = 3'b000;
    step("peak_idle");
    check("peak_kept_const", 32'(bus.disp_val), 32'd1200);
    set_ch(0, 16'h0, 16'h0, 16'd300);
    bus.sample_valid = 3'b001; bus.peak_clr = 1'b1;
    step("peak_clr_sample");
    bus.sample_valid = 3'b000; bus.peak_clr = 1'b0;
    step("peak_show300");
    check("peak_clr_sample_const", 32'(bus.disp_val), 32'd300);
    bus.peak_clr = 1'b1;
    step("peak_clr_only");
    bus.peak_clr = 1'b0;
    step("peak_show0");
    check("peak_clr_only_const", 32'(bus.disp_val), 32'd0);

    // Reset in the middle of an auto-scan with nonzero peaks
    set_ch(0, 16'h0, 16'h0, 16'd111);
    set_ch(1, 16'h0, 16'h0, 16'd222);
    set_ch(2, 16'h0, 16'h0, 16'd333);
    bus.sample_valid = 3'b111;
    step("load_peaks");
    bus.sample_valid = 3'b000;
    bus.auto_scan = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step("seek_ch2");
      if (bus.disp_ch == 2'd2) found = 1;
    end
    check("seek_ch2_timeout", 32'(found), 32'd1);
    reset_n = 1'b0;
    step("midreset");
    check("midreset_ch_const", 32'(bus.disp_ch), 32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) step("after_reset");

    // Randomized operation against the model
    for (int k = 0; k < 1500; k++) begin
      reset_n = ($urandom_range(99) != 0);
      if ($urandom_range(9) == 0) bus.display_mode = 2'($urandom_range(3));
      if ($urandom_range(29) == 0) bus.auto_scan = ~bus.auto_scan;
      if ($urandom_range(7) == 0) bus.ch_sel = 2'($urandom_range(3));
      bus.hold = ($urandom_range(6) == 0);
      bus.peak_clr = ($urandom_range(19) == 0);
      bus.sample_valid = 3'($urandom_range(7));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0)
          set_ch(i, 16'($urandom), 16'($urandom), 16'($urandom_range(4000)));
      end
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
